// File: rtl/cnt_seq_pkg.sv
// Shared types for the counter run-control sequencer: FSM state encoding
// and the one-shot / periodic mode constants.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/cnt_core.sv
// N-bit up-counter datapath: synchronous clear has priority over enable,
// otherwise the value holds. Wraps modulo 2^N.
module cnt_core #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [N-1:0] o_count
);

  logic [N-1:0] r_count;

  // Counter register: clear, increment or hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + N'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Run-control sequencer for the N-bit up-counter. Takes a limit and mode
// through a valid/ready config port and walks the counter through
// start / pause / resume / abort, flagging terminal count.
// Optional tick prescaler: define CNT_SEQ_PRESCALE_EN to add the
// cfg_prescale port and a PW-bit divider in front of the count tick.
module cnt_seq_ctrl #(
  parameter int N = 8
`ifdef CNT_SEQ_PRESCALE_EN
  , parameter int PW = 4
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [N-1:0]  cfg_limit,
  input  logic          cfg_periodic,
`ifdef CNT_SEQ_PRESCALE_EN
  input  logic [PW-1:0] cfg_prescale,
`endif
  input  logic          start,
  input  logic          stop,
  input  logic          abort,
  output logic [N-1:0]  count,
  output logic          busy,
  output logic          tc_pulse,
  output logic          done
);

  import cnt_seq_pkg::*;

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_limit;
  logic         r_periodic;
  logic         r_tc;
  logic         r_busy;
  logic         r_done;
  logic         r_ready;

  logic         w_tc_next;
  logic         w_clr;
  logic         w_en;
  logic         w_tick;
  logic         w_cfg_fire;
  logic         w_at_limit;
  logic [N-1:0] w_count;

  assign w_cfg_fire = cfg_valid & r_ready;
  assign w_at_limit = (w_count == r_limit);

`ifdef CNT_SEQ_PRESCALE_EN
  logic [PW-1:0] r_presc;
  logic [PW-1:0] r_presc_cnt;
  logic          w_presc_clr;
  logic          w_presc_adv;

  assign w_tick = (r_presc_cnt == r_presc);

  // The divider restarts with every fresh run or abort, and only advances
  // on RUN cycles that are not being paused (a terminal tick still counts).
  assign w_presc_clr = abort | (((r_state == IDLE) || (r_state == DONE)) & start);
  assign w_presc_adv = (r_state == RUN) & (~stop | (w_tick & w_at_limit));

  // Prescaler: divide-by-(presc+1) tick generator, held while paused.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc     <= '0;
      r_presc_cnt <= '0;
    end else begin
      if (w_cfg_fire) begin
        r_presc <= cfg_prescale;
      end
      if (w_presc_clr) begin
        r_presc_cnt <= '0;
      end else if (w_presc_adv) begin
        r_presc_cnt <= w_tick ? '0 : (r_presc_cnt + PW'(1));
      end
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Next-state and counter control; abort overrides everything, and a
  // terminal tick completes even when stop arrives in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_en         = 1'b0;
    w_tc_next    = 1'b0;
    if (abort) begin
      w_state_next = IDLE;
      w_clr        = 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_state_next = RUN;
            w_clr        = 1'b1;
          end
        end
        RUN: begin
          if (w_tick && w_at_limit) begin
            w_tc_next = 1'b1;
            if (r_periodic == MODE_PERIODIC) begin
              w_clr        = 1'b1;
              w_state_next = stop ? PAUSE : RUN;
            end else begin
              w_state_next = DONE;
            end
          end else if (stop) begin
            w_state_next = PAUSE;
          end else begin
            w_en = w_tick;
          end
        end
        PAUSE: begin
          if (start) begin
            w_state_next = RUN;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_clr        = 1'b1;
        end
      endcase
    end
  end

  // State, configuration and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_limit    <= '0;
      r_periodic <= MODE_ONESHOT;
      r_tc       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      if (w_cfg_fire) begin
        r_limit    <= cfg_limit;
        r_periodic <= cfg_periodic;
      end
      r_state <= w_state_next;
      r_tc    <= w_tc_next;
      r_busy  <= (w_state_next == RUN) || (w_state_next == PAUSE);
      r_done  <= (w_state_next == DONE);
      r_ready <= (w_state_next == IDLE) || (w_state_next == DONE);
    end
  end

  cnt_core #(
    .N(N)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_count)
  );

  assign count     = w_count;
  assign busy      = r_busy;
  assign tc_pulse  = r_tc;
  assign done      = r_done;
  assign cfg_ready = r_ready;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: a behavioural model tracks the
// sequencer phase, count and config; a compare process checks every cycle,
// and directed scenarios pin the model with literal expectations before a
// randomized run.
module tb_cnt_seq_ctrl;

  localparam int N = 8;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_PAUSE = 2, PH_DONE = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [N-1:0] cfg_limit = '0;
  logic         cfg_periodic = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] count;
  logic         busy;
  logic         tc_pulse;
  logic         done;
`ifdef CNT_SEQ_PRESCALE_EN
  logic [3:0]   cfg_prescale = 4'd0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.N(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_limit    (cfg_limit),
    .cfg_periodic (cfg_periodic),
`ifdef CNT_SEQ_PRESCALE_EN
    .cfg_prescale (cfg_prescale),
`endif
    .start        (start),
    .stop         (stop),
    .abort        (abort),
    .count        (count),
    .busy         (busy),
    .tc_pulse     (tc_pulse),
    .done         (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_ph  = PH_IDLE;
  int m_cnt = 0;
  int m_lim = 0;
  bit m_per = 1'b0;
  bit m_tc  = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    int ph, cnt, lim;
    bit per, tc;
    if (!reset_n) begin
      m_ph <= PH_IDLE; m_cnt <= 0; m_lim <= 0; m_per <= 1'b0; m_tc <= 1'b0;
    end else begin
      ph = m_ph; cnt = m_cnt; lim = m_lim; per = m_per; tc = 1'b0;
      // config accepted whenever the sequencer is idle or finished
      if (cfg_valid && (m_ph == PH_IDLE || m_ph == PH_DONE)) begin
        lim = int'(cfg_limit);
        per = cfg_periodic;
      end
      if (abort) begin
        ph = PH_IDLE; cnt = 0;
      end else if (m_ph == PH_IDLE || m_ph == PH_DONE) begin
        if (start) begin ph = PH_RUN; cnt = 0; end
      end else if (m_ph == PH_PAUSE) begin
        if (start) ph = PH_RUN;
      end else begin
        if (m_cnt == m_lim) begin
          tc = 1'b1;
          if (m_per) begin cnt = 0; ph = stop ? PH_PAUSE : PH_RUN; end
          else ph = PH_DONE;
        end else if (stop) begin
          ph = PH_PAUSE;
        end else begin
          cnt = (m_cnt + 1) % 256;
        end
      end
      m_ph <= ph; m_cnt <= cnt; m_lim <= lim; m_per <= per; m_tc <= tc;
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      chk("model_count", 32'(count), 32'(m_cnt));
      chk("model_tc", 32'(tc_pulse), 32'(m_tc));
      chk("model_busy", 32'(busy), 32'(m_ph == PH_RUN || m_ph == PH_PAUSE));
      chk("model_done", 32'(done), 32'(m_ph == PH_DONE));
      chk("model_ready", 32'(cfg_ready), 32'(m_ph == PH_IDLE || m_ph == PH_DONE));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_abort();
    abort = 1'b1; cyc(); abort = 1'b0;
  endtask

  task automatic cfg_start(input int lim, input bit per);
    cfg_valid = 1'b1; cfg_limit = N'(lim); cfg_periodic = per; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    int r;
    // reset values
    repeat (3) cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tc", 32'(tc_pulse), 0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    cyc();

    // start with no config: limit 0 one-shot
    start = 1'b1; cyc(); start = 1'b0;
    chk("nocfg_busy", 32'(busy), 1);
    cyc();
    chk("nocfg_done", 32'(done), 1);
    chk("nocfg_tc", 32'(tc_pulse), 1);
    $display("txn: start without config -> done=%0d", done);

    // one-shot limit 3
    cfg_start(3, 1'b0);
    chk("os_count0", 32'(count), 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("os_count", 32'(count), 32'(i));
      chk("os_tc_low", 32'(tc_pulse), 0);
    end
    cyc();
    chk("os_tc", 32'(tc_pulse), 1);
    chk("os_done", 32'(done), 1);
    chk("os_hold", 32'(count), 3);
    chk("os_busy", 32'(busy), 0);
    cyc();
    chk("os_tc_one", 32'(tc_pulse), 0);
    chk("os_hold2", 32'(count), 3);
    $display("txn: one-shot limit 3 -> count=%0d done=%0d", count, done);

    // periodic limit 2, config offered during RUN is ignored
    do_abort();
    cfg_start(2, 1'b1);
    cfg_valid = 1'b1; cfg_limit = N'(5);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("per_count", 32'(count), 32'(i % 3));
      chk("per_tc", 32'(tc_pulse), 32'(i % 3 == 0));
      chk("per_ready", 32'(cfg_ready), 0);
    end
    cfg_valid = 1'b0;
    $display("txn: periodic limit 2 -> count=%0d", count);

    // pause / resume, limit 6 one-shot
    do_abort();
    cfg_start(6, 1'b0);
    repeat (4) cyc();
    chk("pr_count4", 32'(count), 4);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("pr_pause", 32'(count), 4);
    chk("pr_busy", 32'(busy), 1);
    repeat (5) begin
      cyc();
      chk("pr_hold", 32'(count), 4);
    end
    start = 1'b1; cyc(); start = 1'b0;
    chk("pr_resume", 32'(count), 4);
    cyc(); chk("pr_c5", 32'(count), 5);
    cyc(); chk("pr_c6", 32'(count), 6); chk("pr_tc0", 32'(tc_pulse), 0);
    cyc(); chk("pr_tc", 32'(tc_pulse), 1); chk("pr_done", 32'(done), 1);
    $display("txn: pause/resume limit 6 -> count=%0d", count);

    // abort + stop + start together at count 7
    do_abort();
    cfg_start(10, 1'b0);
    repeat (7) cyc();
    chk("ab_c7", 32'(count), 7);
    abort = 1'b1; stop = 1'b1; start = 1'b1;
    cyc();
    abort = 1'b0; stop = 1'b0; start = 1'b0;
    chk("ab_count", 32'(count), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_ready", 32'(cfg_ready), 1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("ab_restart", 32'(count), 0);
    cyc(); chk("ab_c1", 32'(count), 1);
    $display("txn: abort at 7 -> restart count=%0d", count);

    // limit 0 periodic: tc every tick, count stays 0
    do_abort();
    cfg_start(0, 1'b1);
    repeat (3) begin
      cyc();
      chk("z_tc", 32'(tc_pulse), 1);
      chk("z_count", 32'(count), 0);
    end
    $display("txn: periodic limit 0 -> tc=%0d", tc_pulse);

    // terminal tick coincident with stop
    do_abort();
    cfg_start(2, 1'b1);
    repeat (2) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("ts_tc", 32'(tc_pulse), 1);
    chk("ts_count", 32'(count), 0);
    chk("ts_busy", 32'(busy), 1);
    cyc();
    chk("ts_paused", 32'(count), 0);
    do_abort();
    cfg_start(2, 1'b0);
    repeat (2) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("ts_os_done", 32'(done), 1);
    chk("ts_os_tc", 32'(tc_pulse), 1);
    $display("txn: terminal+stop -> done=%0d", done);

    // asynchronous reset mid-run
    do_abort();
    cfg_start(9, 1'b0);
    repeat (5) cyc();
    chk("ar_c5", 32'(count), 5);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_ready", 32'(cfg_ready), 1);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_tc", 32'(tc_pulse), 0);
    cyc();
    reset_n = 1'b1;
    $display("txn: async reset mid-run -> count=%0d", count);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 15));
      cfg_limit    = (r == 15) ? N'(255) : N'(r % 8);
      cfg_periodic = 1'($urandom_range(0, 1));
      cfg_valid    = ($urandom_range(0, 9) < 3);
      start        = ($urandom_range(0, 9) == 0);
      stop         = ($urandom_range(0, 19) == 0);
      abort        = ($urandom_range(0, 49) == 0);
      cyc();
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0;
    cyc();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
